// File: rtl/rtc_bcd_clock.sv
// rtc_bcd_clock: free-running BCD calendar clock resynchronised to RTC snapshots; alarm built only with RTC_CLOCK_ALARM_EN
module rtc_bcd_clock #(
  parameter int c_clk_mhz  = 50,
  parameter int c_tick_div = c_clk_mhz * 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [55:0] datetime_i,
  output logic [55:0] datetime_o,
  output logic        pps,
  output logic        valid,
  input  logic        alarm_wr,
  input  logic [23:0] alarm_i,
  input  logic        alarm_ack,
  output logic        alarm_o
);
  localparam int pw = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
  localparam logic [pw-1:0] pre_max = pw'(c_tick_div - 1);
  localparam logic [55:0] dt_rst = 56'h00_01_01_01_00_00_00;
  logic [pw-1:0] pre_q, pre_d;
  logic [55:0]   dt_q, dt_d, dt_inc;
  logic          pps_q, pps_d, valid_q, valid_d;
  logic [7:0]    yy, mo, dd, wd, hh, mi, ss, dim;
  logic [1:0]    yr_mod4;
  logic          c_s, c_m, c_h, c_d, c_mo, tc;
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    return (b[3:0] == 4'h9) ? {b[7:4] + 4'h1, 4'h0} : b + 8'h1;
  endfunction
  function automatic logic [7:0] bcd_wrap(input logic [7:0] b, input logic [7:0] lim, input logic [7:0] base);
    return (b >= lim) ? base : bcd_inc(b);
  endfunction
  // one-second increment of the current datetime with the full BCD carry chain
  always_comb begin
    {yy, mo, dd, wd, hh, mi, ss} = dt_q;
    yr_mod4 = {yy[4], 1'b0} + yy[1:0];
    dim = (mo == 8'h02) ? ((yr_mod4 == 2'b00) ? 8'h29 : 8'h28) :
          (mo == 8'h04 || mo == 8'h06 || mo == 8'h09 || mo == 8'h11) ? 8'h30 : 8'h31;
    c_s  = ss >= 8'h59;
    c_m  = c_s && mi >= 8'h59;
    c_h  = c_m && hh >= 8'h23;
    c_d  = c_h && dd >= dim;
    c_mo = c_d && mo >= 8'h12;
    dt_inc = {c_mo ? ((yy == 8'h99) ? 8'h00 : bcd_inc(yy)) : yy,
              c_d ? bcd_wrap(mo, 8'h12, 8'h01) : mo,
              c_h ? bcd_wrap(dd, dim, 8'h01) : dd,
              c_h ? bcd_wrap(wd, 8'h07, 8'h01) : wd,
              c_m ? bcd_wrap(hh, 8'h23, 8'h00) : hh,
              c_s ? bcd_wrap(mi, 8'h59, 8'h00) : mi,
              bcd_wrap(ss, 8'h59, 8'h00)};
  end
  // sync overrides the local tick; a seconds change realigns the prescaler and raises pps
  always_comb begin
    tc      = pre_q == pre_max;
    dt_d    = sync ? datetime_i : tc ? dt_inc : dt_q;
    pre_d   = ((sync && datetime_i[7:0] != dt_q[7:0]) || tc) ? '0 : pre_q + pw'(1);
    pps_d   = dt_d[7:0] != dt_q[7:0];
    valid_d = valid_q | sync;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      dt_q    <= dt_rst;
      pps_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      dt_q    <= dt_d;
      pps_q   <= pps_d;
      valid_q <= valid_d;
    end
  end
  assign datetime_o = dt_q;
  assign pps        = pps_q;
  assign valid      = valid_q;
`ifdef RTC_CLOCK_ALARM_EN
  logic [23:0] alarm_q, alarm_d;
  logic        hit_q, hit_d;
  // alarm time register and sticky match flag; a new match beats ack
  always_comb begin
    alarm_d = alarm_wr ? alarm_i : alarm_q;
    hit_d   = (pps_q && dt_q[23:0] == alarm_q) || (hit_q && !alarm_ack);
  end
  // alarm registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      hit_q   <= hit_d;
    end
  end
  assign alarm_o = hit_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_wr, alarm_i, alarm_ack};
  assign alarm_o = 1'b0;
`endif
endmodule

// File: doc/rtc_bcd_clock.md
Name: rtc_bcd_clock

Overview:
- Downstream consumer of the MCP7940N reader's 56-bit BCD datetime and its `tick` strobe.
- Keeps a free-running local BCD calendar clock that advances once per second from the system clock.
- Resynchronises to the RTC snapshot on every `sync` strobe.
- Gives the CPU/display a datetime that advances every second with 1-clock-cycle update granularity, and a one-second pulse, independent of I2C polling rate.

Parameters:
c_clk_mhz, 50, system clock frequency in MHz; used only to derive the default of c_tick_div.
c_tick_div, c_clk_mhz*1000000, clock cycles per local second; the bench overrides it to a small value (e.g. 8).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
sync  in  1  one-cycle strobe; datetime_i is valid (driven by the RTC reader's tick).
datetime_i  in  56  BCD {YY,MM,DD,WD,HH,MM,SS} from the RTC reader.
datetime_o  out  56  local BCD {YY,MM,DD,WD,HH,MM,SS}, registered.
pps  out  1  one-cycle pulse whenever the seconds field changes.
valid  out  1  1 once at least one sync has been accepted since reset.
alarm_wr  in  1  load alarm_i into the alarm register (optional feature).
alarm_i  in  24  BCD {HH,MM,SS} alarm time (optional feature).
alarm_ack  in  1  clears alarm_o (optional feature).
alarm_o  out  1  sticky alarm flag (optional feature).

Behaviour:
- Reset values:
  - datetime_o = 56'h00_01_01_01_00_00_00 (year 00, month 01, day 01, weekday 1, 00:00:00).
  - pps = 0, valid = 0, alarm_o = 0, alarm register = 0, prescaler = 0.
- Reset has priority over every other input in the same cycle.
- Prescaler:
  - Counts 0..c_tick_div-1 and wraps.
  - tc = (prescaler == c_tick_div-1).
- Increment on tc when sync=0: registered result at the next edge; datetime_o changes 1 cycle after the tc cycle. The BCD carry chain is evaluated combinationally from the current datetime_o.
  - Seconds: if SS >= 59 (binary compare of the BCD byte), SS := 00 and carry; otherwise BCD+1 (low nibble 9 -> 0 with high nibble +1).
  - Minutes: same rule as seconds.
  - Hours: same rule with limit 23.
  - Day carry (hours wrap):
    - Weekday: WD >= 7 -> 1, else +1.
    - Day: DD >= days_in_month -> 01 with carry into month, else BCD+1.
  - Month: MM >= 12 -> 01 with carry into year, else BCD+1.
  - Year: 99 -> 00, else BCD+1.
  - days_in_month:
    - Months 04, 06, 09, 11: 30.
    - Month 02: 29 if year (as binary of the BCD value 0..99) is divisible by 4, else 28.
    - All others, including illegal months: 31.
- pps:
  - Asserted for exactly the cycle in which the new seconds value appears on datetime_o.
  - Not asserted by a sync whose seconds equal the current local seconds.
- Sync (sync=1):
  - datetime_o := datetime_i at the next edge, loaded verbatim with no range checking. Out-of-range fields are corrected only by the increment wrap rules above.
  - valid := 1.
  - If datetime_i[7:0] != datetime_o[7:0]: prescaler := 0 (phase realigned to the RTC second edge) and pps = 1 in that update cycle. Otherwise the prescaler continues undisturbed.
- Simultaneous sync and tc:
  - sync wins; no local increment that cycle.
  - If seconds are equal, the prescaler wraps to 0 normally.
- Between syncs the clock free-runs indefinitely; valid stays 1 until reset.

Optional Feature:
- RTC_CLOCK_ALARM_EN defined:
  - alarm_wr loads alarm_i.
  - When datetime_o[23:0] becomes equal to the alarm register (evaluated in the cycle pps=1), alarm_o := 1 on the next edge.
  - alarm_o stays 1 until alarm_ack. If ack and a new match occur in the same cycle, set wins.
- RTC_CLOCK_ALARM_EN undefined:
  - Ports remain present; alarm_wr, alarm_i and alarm_ack are ignored.
  - alarm_o is constant 0; no alarm logic is synthesised.

Test Plan:
- Reset, c_tick_div=8, no sync -> datetime_o=00_01_01_01_00_00_00 and valid=0; after 8 cycles seconds=01 with pps high for 1 cycle.
- sync with datetime_i=99_12_31_07_23_59_59, then one tc -> 00_01_01_01_00_00_00 with pps=1.
- Load 24_02_28_03_23_59_59 -> 24_02_29_04_00_00_00; load 23_02_28_03_23_59_59 -> 23_03_01_04_00_00_00; load 24_04_30_02_23_59_59 -> 24_05_01_03_00_00_00.
- Sync with the same seconds as local, prescaler at 5 -> no pps, prescaler continues, next tc at original phase; sync with different seconds -> pps that cycle, prescaler=0, next increment 8 cycles later.
- sync asserted on the tc cycle with datetime_i seconds=30 -> datetime_o seconds=30, not 31; subsequent increment c_tick_div cycles later.
- With RTC_CLOCK_ALARM_EN: alarm_i=00_00_03 after reset -> alarm_o rises 1 cycle after seconds=03, holds until alarm_ack; without the macro alarm_o stays 0 throughout.
